// File: rtl/sdp_bwe_bram_pipe.sv
// sdp_bwe_bram_pipe
// Simple-dual-port byte-write RAM with an RD_LATENCY-deep read pipeline that
// stalls as a unit under response back-pressure, write-first byte-merged
// bypass for same-cycle read/write collisions, and a clear sequencer that
// zeroes every word after reset.
// Optional feature macro: SDP_BWE_BRAM_PARITY_EN adds one even-parity bit per
// column, stored on write and checked at the last pipeline stage.
module sdp_bwe_bram_pipe #(
  parameter int NB_COL     = 8,
  parameter int COL_WIDTH  = 8,
  parameter int RAM_DEPTH  = 512,
  parameter int RD_LATENCY = 2,  // legal range 1..4
  localparam int AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1,
  localparam int DW = NB_COL * COL_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  output logic              init_done_o,
  input  logic [NB_COL-1:0] wea,
  input  logic [AW-1:0]     addra,
  input  logic [DW-1:0]     dina,
  input  logic              rd_req_valid_i,
  output logic              rd_req_ready_o,
  input  logic [AW-1:0]     addrb,
  output logic              rd_valid_o,
  input  logic              rd_ready_i,
  output logic [DW-1:0]     doutb,
  output logic [NB_COL-1:0] rd_par_err_o
);

`ifdef SDP_BWE_BRAM_PARITY_EN
  localparam int SW = DW + NB_COL;  // pipeline word: {parity, data}
`else
  localparam int SW = DW;
`endif
  localparam logic [AW-1:0] LAST_ADDR = AW'(RAM_DEPTH - 1);

  typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_t;

  state_t            state_reg, state_next;
  logic [AW-1:0]     clr_cnt_reg, clr_cnt_next;

  logic              stall;
  logic              accept;
  logic              wr_in_range;
  logic              rd_in_range;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic [NB_COL-1:0] wr_en;

  logic [DW-1:0]     mem [RAM_DEPTH];
  logic [DW-1:0]     rd_q_reg;
  logic [DW-1:0]     byp_data_reg;
  logic [NB_COL-1:0] byp_mask_reg;
  logic              rd_zero_reg;
  logic [DW-1:0]     s0_data;
  logic [SW-1:0]     stage_out [RD_LATENCY];
  logic [RD_LATENCY-1:0] valid_reg;

`ifdef SDP_BWE_BRAM_PARITY_EN
  logic [NB_COL-1:0] par_mem [RAM_DEPTH];
  logic [NB_COL-1:0] wr_par;
  logic [NB_COL-1:0] par_q_reg;
  logic [NB_COL-1:0] s0_par;
`endif

  genvar gi;

  // State register and clear counter; reset restarts the clear from word 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= CLEAR;
      clr_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      clr_cnt_reg <= clr_cnt_next;
    end
  end

  // Next state: walk the counter through every word, then open for traffic.
  always_comb begin
    state_next   = state_reg;
    clr_cnt_next = clr_cnt_reg;
    case (state_reg)
      CLEAR: begin
        if (clr_cnt_reg == LAST_ADDR) begin
          state_next = READY;
        end else begin
          clr_cnt_next = clr_cnt_reg + AW'(1);
        end
      end
      READY:   state_next = READY;
      default: state_next = CLEAR;
    endcase
  end

  assign init_done_o    = (state_reg == READY);
  assign stall          = rd_valid_o & ~rd_ready_i;
  assign rd_req_ready_o = init_done_o & ~stall;
  assign accept         = rd_req_valid_i & rd_req_ready_o;
  assign rd_valid_o     = valid_reg[RD_LATENCY-1];

  // Addresses beyond RAM_DEPTH only exist when the depth is not a power of two.
  generate
    if (RAM_DEPTH == (1 << AW)) begin : g_pow2
      assign wr_in_range = 1'b1;
      assign rd_in_range = 1'b1;
    end else begin : g_npow2
      assign wr_in_range = ({1'b0, addra} < (AW + 1)'(RAM_DEPTH));
      assign rd_in_range = ({1'b0, addrb} < (AW + 1)'(RAM_DEPTH));
    end
  endgenerate

  // Single write port shared by the clear sequencer and the user.
  always_comb begin
    wr_addr = addra;
    wr_data = dina;
    wr_en   = '0;
    if (state_reg == CLEAR) begin
      wr_addr = clr_cnt_reg;
      wr_data = '0;
      wr_en   = '1;
    end else if (wr_in_range) begin
      wr_en = wea;
    end
  end

`ifdef SDP_BWE_BRAM_PARITY_EN
  generate
    for (gi = 0; gi < NB_COL; gi++) begin : g_wr_par
      // Even parity; the all-zero clear word naturally gets parity 0.
      assign wr_par[gi] = ^wr_data[gi*COL_WIDTH +: COL_WIDTH];
    end
  endgenerate
`endif

  // Byte-enabled RAM write.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NB_COL; c++) begin
      if (wr_en[c]) begin
        mem[wr_addr][c*COL_WIDTH +: COL_WIDTH] <= wr_data[c*COL_WIDTH +: COL_WIDTH];
`ifdef SDP_BWE_BRAM_PARITY_EN
        par_mem[wr_addr][c] <= wr_par[c];
`endif
      end
    end
  end

  // Stage 0: registered RAM read (old data) plus the same-cycle bypass info.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q_reg     <= '0;
      byp_data_reg <= '0;
      byp_mask_reg <= '0;
      rd_zero_reg  <= 1'b0;
`ifdef SDP_BWE_BRAM_PARITY_EN
      par_q_reg    <= '0;
`endif
    end else if (accept) begin
      rd_q_reg     <= mem[addrb];
      byp_data_reg <= dina;
      byp_mask_reg <= (wr_in_range && (addra == addrb)) ? wea : '0;
      rd_zero_reg  <= ~rd_in_range;
`ifdef SDP_BWE_BRAM_PARITY_EN
      par_q_reg    <= par_mem[addrb];
`endif
    end
  end

  // Byte merge: columns written in the accept cycle take the new data.
  generate
    for (gi = 0; gi < NB_COL; gi++) begin : g_merge
      assign s0_data[gi*COL_WIDTH +: COL_WIDTH] =
        rd_zero_reg        ? '0 :
        byp_mask_reg[gi]   ? byp_data_reg[gi*COL_WIDTH +: COL_WIDTH] :
                             rd_q_reg[gi*COL_WIDTH +: COL_WIDTH];
`ifdef SDP_BWE_BRAM_PARITY_EN
      assign s0_par[gi] =
        rd_zero_reg        ? 1'b0 :
        byp_mask_reg[gi]   ? ^byp_data_reg[gi*COL_WIDTH +: COL_WIDTH] :
                             par_q_reg[gi];
`endif
    end
  endgenerate

`ifdef SDP_BWE_BRAM_PARITY_EN
  assign stage_out[0] = {s0_par, s0_data};
`else
  assign stage_out[0] = s0_data;
`endif

  // Valid bits shift as one unit; a stall freezes the whole pipe.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg <= '0;
    end else if (!stall) begin
      valid_reg[0] <= accept;
      for (int k = 1; k < RD_LATENCY; k++) begin
        valid_reg[k] <= valid_reg[k-1];
      end
    end
  end

  generate
    for (gi = 1; gi < RD_LATENCY; gi++) begin : g_stage
      logic [SW-1:0] data_reg;
      // Only a valid word overwrites a stage, so doutb holds across bubbles.
      always_ff @(posedge clk) begin
        if (rst) begin
          data_reg <= '0;
        end else if (!stall && valid_reg[gi-1]) begin
          data_reg <= stage_out[gi-1];
        end
      end
      assign stage_out[gi] = data_reg;
    end
  endgenerate

  assign doutb = stage_out[RD_LATENCY-1][DW-1:0];

`ifdef SDP_BWE_BRAM_PARITY_EN
  generate
    for (gi = 0; gi < NB_COL; gi++) begin : g_par_chk
      assign rd_par_err_o[gi] = rd_valid_o &
        ((^stage_out[RD_LATENCY-1][gi*COL_WIDTH +: COL_WIDTH]) ^ stage_out[RD_LATENCY-1][DW + gi]);
    end
  endgenerate
`else
  assign rd_par_err_o = '0;
`endif

endmodule

// File: tb/tb_sdp_bwe_bram_pipe.sv
// Testbench for sdp_bwe_bram_pipe (RAM_DEPTH=16, RD_LATENCY=3).
// A word-array reference model with a response queue predicts every response;
// directed steps cover clear, byte writes, collision, back-pressure, reset
// and parity (SDP_BWE_BRAM_PARITY_EN), followed by a random phase.
module tb_sdp_bwe_bram_pipe;
  localparam int NB_COL    = 8;
  localparam int COL_WIDTH = 8;
  localparam int DEPTH     = 16;
  localparam int LAT       = 3;
  localparam int AW        = 4;
  localparam int DW        = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic              init_done_o;
  logic [NB_COL-1:0] wea;
  logic [AW-1:0]     addra;
  logic [DW-1:0]     dina;
  logic              rd_req_valid_i;
  logic              rd_req_ready_o;
  logic [AW-1:0]     addrb;
  logic              rd_valid_o;
  logic              rd_ready_i;
  logic [DW-1:0]     doutb;
  logic [NB_COL-1:0] rd_par_err_o;

  always #5 clk = ~clk;

  sdp_bwe_bram_pipe #(
    .NB_COL(NB_COL), .COL_WIDTH(COL_WIDTH), .RAM_DEPTH(DEPTH), .RD_LATENCY(LAT)
  ) dut (
    .clk(clk), .rst(rst), .init_done_o(init_done_o),
    .wea(wea), .addra(addra), .dina(dina),
    .rd_req_valid_i(rd_req_valid_i), .rd_req_ready_o(rd_req_ready_o), .addrb(addrb),
    .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i),
    .doutb(doutb), .rd_par_err_o(rd_par_err_o)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int n_resp   = 0;
  logic last_acc;

  // Reference model: word contents, columns with a corrupted stored bit,
  // readiness, and the ordered list of responses still owed.
  logic [DW-1:0]     model_mem [DEPTH];
  logic [NB_COL-1:0] model_bad [DEPTH];
  logic              model_ready;
  int                clear_left;
  logic [DW-1:0]     exp_data_q [$];
  logic [NB_COL-1:0] exp_err_q [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int a = 0; a < DEPTH; a++) begin
      model_mem[a] = '0;
      model_bad[a] = '0;
    end
    exp_data_q.delete();
    exp_err_q.delete();
    model_ready = 1'b0;
    clear_left  = DEPTH;
  endtask

  // One clock: check and account at the falling edge, return 1 after the rise.
  task automatic tick();
    logic acc, cons;
    logic [DW-1:0] ed;
    logic [NB_COL-1:0] ee;
    @(negedge clk);
    chk("init_done", init_done_o, model_ready);
    chk("req_ready", rd_req_ready_o, model_ready && !(rd_valid_o && !rd_ready_i));
    if (!rd_valid_o) chk("par_err_idle", rd_par_err_o, 0);
    acc  = rd_req_valid_i && rd_req_ready_o;
    cons = rd_valid_o && rd_ready_i;
    last_acc = 1'b0;
    if (rst) begin
      model_reset();
    end else begin
      if (cons) begin
        n_assert++;
        assert (exp_data_q.size() != 0) else begin
          n_fail++;
          $error("FAIL resp_unexpected: observed response 0x%0h, expected none", doutb);
        end
        if (exp_data_q.size() != 0) begin
          ed = exp_data_q.pop_front();
          ee = exp_err_q.pop_front();
          chk("resp_data", doutb, ed);
          chk("resp_par_err", rd_par_err_o, ee);
          n_resp++;
        end
      end
      // Write first, then read: a same-cycle read sees the merged word.
      if (model_ready) begin
        for (int c = 0; c < NB_COL; c++) begin
          if (wea[c]) begin
            model_mem[addra][c*COL_WIDTH +: COL_WIDTH] = dina[c*COL_WIDTH +: COL_WIDTH];
            model_bad[addra][c] = 1'b0;
          end
        end
      end
      if (acc) begin
        exp_data_q.push_back(model_mem[addrb]);
        exp_err_q.push_back(model_bad[addrb]);
        last_acc = 1'b1;
      end
      if (!model_ready) begin
        clear_left--;
        if (clear_left == 0) model_ready = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic issue_read(input int a);
    int n;
    rd_req_valid_i = 1'b1;
    addrb = AW'(a);
    n = 0;
    tick();
    while (!last_acc && n < 50) begin
      tick();
      n++;
    end
    chk("read_accepted", last_acc, 1);
    rd_req_valid_i = 1'b0;
  endtask

  task automatic drain();
    int n;
    rd_req_valid_i = 1'b0;
    wea = '0;
    rd_ready_i = 1'b1;
    n = 0;
    while (exp_data_q.size() > 0 && n < 50) begin
      tick();
      n++;
    end
    chk("drain_empty", exp_data_q.size(), 0);
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!rd_valid_o && n < 20) begin
      tick();
      n++;
    end
    chk("resp_timeout", rd_valid_o, 1);
  endtask

  task automatic count_clear();
    int n;
    n = 0;
    while (!init_done_o && n < 40) begin
      tick();
      n++;
    end
    chk("clear_cycles", n, DEPTH);
  endtask

  initial begin
    int n, ptr, k, base;
    logic [DW-1:0] held;
    logic [DW-1:0] tmp;

    rst = 1'b1; wea = '0; addra = '0; dina = '0;
    rd_req_valid_i = 1'b0; addrb = '0; rd_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    chk("rst_init_done", init_done_o, 0);
    chk("rst_req_ready", rd_req_ready_o, 0);
    chk("rst_rd_valid", rd_valid_o, 0);
    chk("rst_doutb", doutb, 0);
    chk("rst_par_err", rd_par_err_o, 0);

    // Clear sequence; a user write attempted meanwhile must be ignored.
    rst = 1'b0;
    wea = '1; addra = 4'd2; dina = 64'hFFFF_EEEE_DDDD_CCCC;
    count_clear();
    wea = '0;

    // Every word reads back zero.
    for (int a = 0; a < DEPTH; a++) issue_read(a);
    drain();

    // Byte write over a full word, then latency and data of one read.
    wea = '1; addra = 4'd5; dina = 64'hAAAA_BBBB_CCCC_DDDD; tick();
    wea = 8'h0F; dina = 64'h1111_2222_3333_4444; tick();
    wea = '0;
    rd_req_valid_i = 1'b1; addrb = 4'd5; tick();
    chk("byte_read_accept", last_acc, 1);
    rd_req_valid_i = 1'b0;
    n = 1;
    while (!rd_valid_o && n < 20) begin
      tick();
      n++;
    end
    chk("read_latency", n, LAT);
    chk("byte_write_data", doutb, 64'hAAAA_BBBB_3333_4444);
    drain();

    // Same-cycle collision on word 7 (still zero), top byte only.
    wea = 8'h80; addra = 4'd7; dina = 64'h5A12_3456_789A_BCDE;
    rd_req_valid_i = 1'b1; addrb = 4'd7; tick();
    wea = '0; rd_req_valid_i = 1'b0;
    wait_valid();
    chk("collision_data", doutb, 64'h5A00_0000_0000_0000);
    drain();

    // Back-pressure: stream words 0..9, stall 4 cycles while overwriting.
    for (int a = 0; a < 10; a++) begin
      wea = '1; addra = AW'(a); dina = 64'h0101_0101_0101_0101 * (a + 1); tick();
    end
    wea = '0;
    base = n_resp; ptr = 0; k = 0; held = '0;
    while ((ptr < 10 || exp_data_q.size() > 0) && k < 80) begin
      rd_req_valid_i = (ptr < 10);
      addrb = AW'(ptr);
      rd_ready_i = !(k >= 6 && k < 10);
      wea = '0;
      if (k >= 6 && k < 10) begin
        wea = '1; addra = AW'(k - 3); dina = 64'hDEAD_BEEF_0000_0000 | 64'(k);
      end
      #1;
      if (k >= 6 && k < 10) begin
        chk("stall_rd_valid", rd_valid_o, 1);
        chk("stall_req_ready", rd_req_ready_o, 0);
        if (k == 6) held = doutb;
        else chk("stall_hold", doutb, held);
      end
      tick();
      if (last_acc) ptr++;
      k++;
    end
    chk("bp_all_accepted", ptr, 10);
    chk("bp_resp_count", n_resp - base, 10);
    drain();

    // Mid-operation reset with two reads in flight.
    rd_req_valid_i = 1'b1; addrb = 4'd9; tick();
    addrb = 4'd8; tick();
    rd_req_valid_i = 1'b0;
    rst = 1'b1; tick();
    chk("midrst_rd_valid", rd_valid_o, 0);
    chk("midrst_init_done", init_done_o, 0);
    chk("midrst_doutb", doutb, 0);
    rst = 1'b0;
    count_clear();
    issue_read(9);
    wait_valid();
    chk("post_reset_data", doutb, 0);
    drain();

`ifdef SDP_BWE_BRAM_PARITY_EN
    // Flip one stored data bit of column 2 in word 3 behind the RAM's back.
    tmp = dut.mem[3];
    tmp[17] = ~tmp[17];
    dut.mem[3] = tmp;
    model_mem[3][17] = ~model_mem[3][17];
    model_bad[3][2] = 1'b1;
    issue_read(3);
    wait_valid();
    chk("parity_err", rd_par_err_o, 8'h04);
    chk("parity_data", doutb, 64'h0000_0000_0002_0000);
    drain();
`else
    tmp = '0;
    issue_read(3);
    wait_valid();
    chk("parity_disabled", rd_par_err_o, tmp[NB_COL-1:0]);
    drain();
`endif

    // Random traffic: writes, reads, collisions and back-pressure mixed.
    for (int i = 0; i < 400; i++) begin
      wea            = ($urandom_range(0, 2) == 0) ? NB_COL'($urandom()) : '0;
      addra          = AW'($urandom_range(0, DEPTH - 1));
      dina           = {$urandom(), $urandom()};
      rd_req_valid_i = ($urandom_range(0, 3) != 0);
      addrb          = AW'($urandom_range(0, DEPTH - 1));
      rd_ready_i     = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain();
    chk("final_queue_empty", exp_data_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
